// File: rtl/ad936x_rx_deframer.sv
// rtl/ad936x_rx_deframer.sv - AD936x receive deframer: nibble-to-sample assembly with frame alignment tracking
module ad936x_rx_deframer #(
  parameter int DATA_W      = 6,
  parameter int MAX_CH      = 2,
  parameter int CH_W        = 2,
  parameter int VERIFY_SETS = 4,
  parameter int LOSS_THR    = 3,
  parameter int CNT_W       = 16
) (
  input  logic                         data_clk,
  input  logic                         rst,
  input  logic                         rx_frame_r,
  input  logic                         rx_frame_f,
  input  logic [DATA_W-1:0]            rx_data_r,
  input  logic [DATA_W-1:0]            rx_data_f,
  input  logic [CH_W-1:0]              ch_cnt,
  input  logic                         err_clr,
  output logic [MAX_CH-1:0]            adc_valid,
  output logic [MAX_CH*2*DATA_W-1:0]   adc_data_i,
  output logic [MAX_CH*2*DATA_W-1:0]   adc_data_q,
  output logic                         locked,
  output logic [CNT_W-1:0]             frame_err_cnt
);

  localparam int SAMPLE_W = 2 * DATA_W;
  localparam int NW       = 2 * MAX_CH;
  localparam int KW       = (NW > 2) ? $clog2(NW) : 1;
  localparam int VW       = $clog2(VERIFY_SETS + 1);
  localparam int MW       = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t              state, state_n;
  logic [KW-1:0]       k;
  logic [VW-1:0]       verify_cnt;
  logic [MW-1:0]       miss_cnt;
  logic                set_bad;
  logic                prev_frame;
  logic [CH_W-1:0]     ch_q;
  logic [SAMPLE_W-1:0] wbuf [NW];

  logic [SAMPLE_W-1:0] word;
  logic [CH_W-1:0]     n_m1;
  logic [KW-1:0]       last_k;
  logic                exp_frame, word_bad, at_last, set_bad_now, ch_chg, acquire;
  logic [MAX_CH-1:0]   valid_mask;

  always_comb begin
    word        = {rx_data_r, rx_data_f};
    n_m1        = (ch_q > CH_W'(MAX_CH - 1)) ? CH_W'(MAX_CH - 1) : ch_q;
    last_k      = KW'({n_m1, 1'b1});
    exp_frame   = (k <= KW'(n_m1));
    word_bad    = (rx_frame_r != exp_frame) || (rx_frame_r != rx_frame_f);
    at_last     = (k == last_k);
    set_bad_now = set_bad || word_bad;
    ch_chg      = (ch_cnt != ch_q);
    acquire     = rx_frame_r && !prev_frame;
    valid_mask  = '0;
    for (int c = 0; c < MAX_CH; c++) valid_mask[c] = (c <= int'(n_m1));
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (ch_chg) state_n = SEARCH;
    else begin
      case (state)
        SEARCH: if (acquire) state_n = VERIFY;
        VERIFY: begin
          if (word_bad) state_n = SEARCH;
          else if (at_last && verify_cnt == VW'(VERIFY_SETS)) state_n = LOCKED;
        end
        LOCKED: if (at_last && set_bad_now && miss_cnt == MW'(LOSS_THR - 1)) state_n = SEARCH;
        default: state_n = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      k             <= '0;
      verify_cnt    <= '0;
      miss_cnt      <= '0;
      set_bad       <= 1'b0;
      prev_frame    <= 1'b0;
      ch_q          <= '0;
      adc_valid     <= '0;
      adc_data_i    <= '0;
      adc_data_q    <= '0;
      frame_err_cnt <= '0;
      for (int i = 0; i < NW; i++) wbuf[i] <= '0;
    end else begin
      prev_frame <= rx_frame_r;
      ch_q       <= ch_cnt;
      adc_valid  <= '0;
      if (ch_chg) begin
        k          <= '0;
        verify_cnt <= '0;
        miss_cnt   <= '0;
        set_bad    <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            verify_cnt <= '0;
            miss_cnt   <= '0;
            set_bad    <= 1'b0;
            wbuf[0]    <= word;
            k          <= acquire ? KW'(1) : '0;
          end
          VERIFY: begin
            wbuf[k] <= word;
            k       <= at_last ? '0 : k + KW'(1);
            if (at_last && !word_bad)
              verify_cnt <= (verify_cnt == VW'(VERIFY_SETS)) ? '0 : verify_cnt + VW'(1);
          end
          LOCKED: begin
            wbuf[k] <= word;
            k       <= at_last ? '0 : k + KW'(1);
            set_bad <= at_last ? 1'b0 : set_bad_now;
            if (word_bad && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + CNT_W'(1);
            if (at_last) begin
              if (set_bad_now) miss_cnt <= miss_cnt + MW'(1);
              else begin
                miss_cnt  <= '0;
                adc_valid <= valid_mask;
                // The final Q word is still on the inputs, so it bypasses the buffer.
                for (int c = 0; c < MAX_CH; c++) begin
                  if (c <= int'(n_m1)) begin
                    adc_data_i[c*SAMPLE_W +: SAMPLE_W] <= wbuf[2*c];
                    adc_data_q[c*SAMPLE_W +: SAMPLE_W] <= (2*c + 1 == int'(last_k)) ? word : wbuf[2*c+1];
                  end
                end
              end
            end
          end
          default: k <= '0;
        endcase
      end
      if (err_clr) frame_err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ad936x_rx_deframer.sv
// tb/tb_ad936x_rx_deframer.sv - scoreboard bench for ad936x_rx_deframer
module tb_ad936x_rx_deframer;

  logic        data_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_frame_r = 1'b0, rx_frame_f = 1'b0;
  logic [5:0]  rx_data_r = '0, rx_data_f = '0;
  logic [1:0]  ch_cnt = 2'd1;
  logic        err_clr = 1'b0;
  logic [1:0]  adc_valid;
  logic [23:0] adc_data_i, adc_data_q;
  logic        locked;
  logic [7:0]  frame_err_cnt;

  int checks = 0;
  int errors = 0;
  logic [49:0] sb [$];
  logic [23:0] exp_i = '0, exp_q = '0;

  ad936x_rx_deframer #(.DATA_W(6), .MAX_CH(2), .CH_W(2), .VERIFY_SETS(4), .LOSS_THR(3), .CNT_W(8)) dut (
    .data_clk(data_clk), .rst(rst), .rx_frame_r(rx_frame_r), .rx_frame_f(rx_frame_f),
    .rx_data_r(rx_data_r), .rx_data_f(rx_data_f), .ch_cnt(ch_cnt), .err_clr(err_clr),
    .adc_valid(adc_valid), .adc_data_i(adc_data_i), .adc_data_q(adc_data_q),
    .locked(locked), .frame_err_cnt(frame_err_cnt)
  );

  always #5 data_clk = ~data_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge data_clk) begin
    if (adc_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=%0h required=0", adc_valid);
      end else begin
        chk("sample", {14'd0, adc_valid, adc_data_i, adc_data_q}, {14'd0, sb.pop_front()});
      end
    end
  end

  task automatic drive_word(input logic fr, input logic ff, input logic [11:0] s, input logic clr);
    rx_frame_r = fr;
    rx_frame_f = ff;
    rx_data_r  = s[11:6];
    rx_data_f  = s[5:0];
    err_clr    = clr;
    @(posedge data_clk);
    #1;
    err_clr = 1'b0;
  endtask

  // kind: 0 none, 1 falling-edge FRAME glitch at bad_k, 2 FRAME inverted at bad_k, 3 FRAME inverted on all words
  task automatic send_set(input int n, input logic [11:0] s0, input logic [11:0] s1,
                          input logic [11:0] s2, input logic [11:0] s3,
                          input int bad_k, input int kind, input int clr_k, input bit exp_v);
    logic [11:0] sv [4];
    logic fr, ff;
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    for (int k = 0; k < 2*n; k++) begin
      fr = (k < n);
      ff = fr;
      if (kind == 3 || (kind != 0 && k == bad_k)) begin
        if (kind == 1) ff = ~ff;
        else begin fr = ~fr; ff = ~ff; end
      end
      if (exp_v && k == 2*n-1) begin
        exp_i[11:0] = s0;
        exp_q[11:0] = s1;
        if (n == 2) begin
          exp_i[23:12] = s2;
          exp_q[23:12] = s3;
        end
        sb.push_back({(n == 2) ? 2'b11 : 2'b01, exp_i, exp_q});
      end
      drive_word(fr, ff, sv[k], k == clr_k);
    end
  endtask

  initial begin
    repeat (2) @(posedge data_clk);
    #1;
    chk("reset_locked", locked, 0);
    chk("reset_valid", adc_valid, 0);
    chk("reset_cnt", frame_err_cnt, 0);
    chk("reset_data_i", adc_data_i, 0);
    rst = 1'b0;
    drive_word(0, 0, 12'h000, 0);
    drive_word(0, 0, 12'h000, 0);

    for (int s = 0; s < 4; s++) send_set(2, 12'hABC, 12'h123, 12'h456, 12'h789, -1, 0, -1, 0);
    chk("lock_after4", locked, 0);
    send_set(2, 12'hABC, 12'h123, 12'h456, 12'h789, -1, 0, -1, 0);
    chk("lock_after5", locked, 1);
    send_set(2, 12'hABC, 12'h123, 12'h456, 12'h789, -1, 0, -1, 1);
    send_set(2, 12'h111, 12'h222, 12'h333, 12'h444, -1, 0, -1, 1);
    send_set(2, 12'hFED, 12'h000, 12'h5A5, 12'hA5A, -1, 0, -1, 1);
    chk("cnt_clean", frame_err_cnt, 0);

    send_set(2, 12'h0F0, 12'h0F1, 12'h0F2, 12'h0F3, 1, 1, -1, 0);
    chk("glitch_cnt", frame_err_cnt, 1);
    chk("glitch_locked", locked, 1);
    send_set(2, 12'h101, 12'h202, 12'h303, 12'h404, -1, 0, -1, 1);

    send_set(2, 12'h505, 12'h606, 12'h707, 12'h808, -1, 0, 0, 1);
    chk("clr_cnt", frame_err_cnt, 0);
    send_set(2, 12'h001, 12'h002, 12'h003, 12'h004, 2, 2, -1, 0);
    send_set(2, 12'h001, 12'h002, 12'h003, 12'h004, 2, 2, -1, 0);
    chk("miss2_locked", locked, 1);
    send_set(2, 12'h001, 12'h002, 12'h003, 12'h004, 2, 2, -1, 0);
    chk("miss3_cnt", frame_err_cnt, 3);
    chk("miss3_unlocked", locked, 0);
    for (int s = 0; s < 5; s++) send_set(2, 12'h777, 12'h888, 12'h999, 12'hAAA, -1, 0, -1, 0);
    chk("relock", locked, 1);
    send_set(2, 12'hC01, 12'hC02, 12'hC03, 12'hC04, -1, 0, -1, 1);

    for (int s = 0; s < 4; s++) begin
      send_set(2, 12'h010, 12'h020, 12'h030, 12'h040, 0, 1, -1, 0);
      send_set(2, 12'h010 + 12'(s), 12'h020, 12'h030, 12'h040, -1, 0, -1, 1);
    end
    chk("cnt_seven", frame_err_cnt, 7);
    send_set(2, 12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 1, 2, 1, 0);
    chk("clr_wins", frame_err_cnt, 0);
    send_set(2, 12'h1AA, 12'h1BB, 12'h1CC, 12'h1DD, -1, 0, -1, 1);
    for (int g = 0; g < 33; g++) begin
      send_set(2, 12'h000, 12'h000, 12'h000, 12'h000, -1, 3, -1, 0);
      send_set(2, 12'h000, 12'h000, 12'h000, 12'h000, -1, 3, -1, 0);
      send_set(2, 12'h2A0, 12'h2B0, 12'h2C0, 12'h2D0 + 12'(g), -1, 0, -1, 1);
    end
    chk("cnt_saturated", frame_err_cnt, 8'hFF);
    chk("sat_locked", locked, 1);

    ch_cnt = 2'd0;
    drive_word(0, 0, 12'h000, 0);
    chk("chcnt_unlock", locked, 0);
    send_set(1, 12'h321, 12'h654, 12'h0, 12'h0, -1, 0, -1, 0);
    send_set(1, 12'h321, 12'h654, 12'h0, 12'h0, -1, 0, -1, 0);
    chk("chcnt_cnt_kept", frame_err_cnt, 8'hFF);

    drive_word(1, 1, 12'h321, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_locked", locked, 0);
    chk("async_cnt", frame_err_cnt, 0);
    chk("async_data", {adc_data_i, adc_data_q}, 0);
    exp_i = '0;
    exp_q = '0;
    @(posedge data_clk);
    #1;
    rst = 1'b0;
    drive_word(0, 0, 12'h000, 0);

    for (int s = 0; s < 5; s++) send_set(1, 12'hE01, 12'hE02, 12'h0, 12'h0, -1, 0, -1, 0);
    chk("n1_locked", locked, 1);
    send_set(1, 12'hE11, 12'hE12, 12'h0, 12'h0, -1, 0, -1, 1);
    send_set(1, 12'hE21, 12'hE22, 12'h0, 12'h0, -1, 0, -1, 1);
    drive_word(1, 1, 12'h000, 0);
    chk("n1_ch1_zero", adc_data_i[23:12], 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad936x_rx_deframer.md
Name: ad936x_rx_deframer

Overview:
- Parametrised receive deframer for the AD936x data port. Sits between the DDR capture stage (IDDR/IDELAY outputs in the data_clk domain) and the ADC sample consumers.
- Assembles per-edge nibbles into I/Q samples for 1..MAX_CH channels.
- Acquires and tracks frame alignment with a search/verify/lock state machine.
- Counts frame errors.
- Successor to the fixed 6-bit, 2-channel receive path: width, channel count and lock thresholds are generic, and alignment supervision is new.

Parameters:
- DATA_W, 6, data bits captured per clock edge (6 for LVDS, 12 for CMOS); SAMPLE_W = 2*DATA_W.
- MAX_CH, 2, maximum number of I/Q channels (1..4).
- CH_W, 2, width of ch_cnt; must satisfy 2^CH_W >= MAX_CH.
- VERIFY_SETS, 4, consecutive clean sample sets required before lock.
- LOSS_THR, 3, consecutive bad sets in LOCKED that force re-search.
- CNT_W, 16, frame error counter width.

Ports:
- data_clk  in  1  capture-domain clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_frame_r  in  1  FRAME sampled on the rising edge.
- rx_frame_f  in  1  FRAME sampled on the falling edge.
- rx_data_r  in  DATA_W  data sampled on the rising edge (sample MSB half).
- rx_data_f  in  DATA_W  data sampled on the falling edge (sample LSB half).
- ch_cnt  in  CH_W  active channels minus 1 (N = ch_cnt+1, clamped to MAX_CH).
- err_clr  in  1  synchronous clear of frame_err_cnt.
- adc_valid  out  MAX_CH  per-channel one-cycle sample strobe.
- adc_data_i  out  MAX_CH*SAMPLE_W  I samples; channel c in slice [c*SAMPLE_W +: SAMPLE_W].
- adc_data_q  out  MAX_CH*SAMPLE_W  Q samples; same slicing as adc_data_i.
- locked  out  1  high while in LOCKED.
- frame_err_cnt  out  CNT_W  saturating count of bad words while locked.

Behaviour:
- Word assembly: word = {rx_data_r, rx_data_f}, one word per data_clk.
- Sample set: 2N words in order I0,Q0,I1,Q1,...; word index k = 0..2N-1.
- Expected frame: expected frame = (k < N), i.e. FRAME high for the first half of the set.
- Bad word: rx_frame_r != expected, or rx_frame_r != rx_frame_f (glitch).
- Reset (async): state = SEARCH; k = 0; locked = 0; adc_valid = 0; adc_data_i/q = 0; frame_err_cnt = 0; internal verify/miss counters = 0; frame history = 0.
- SEARCH:
  - A word with rx_frame_r=1 and the previous word's rx_frame_r=0 is taken as k=0.
  - Go to VERIFY, next word is k=1.
  - N=1 special case: a 1/0 toggle pattern qualifies identically.
- VERIFY:
  - Any bad word -> SEARCH.
  - VERIFY_SETS consecutive clean sets -> LOCKED.
  - No adc_valid in this state.
- LOCKED:
  - locked=1.
  - Each bad word increments frame_err_cnt, saturating at all-ones.
  - A set with no bad word clears the miss counter; a set with >=1 bad word increments it.
  - Miss counter reaching LOSS_THR -> SEARCH on the cycle after the last word of that set; locked drops the same cycle.
  - The set that trips the threshold produces no adc_valid.
- Output timing:
  - In LOCKED, at the last word of a clean set, adc_data_i/q for channels 0..N-1 update together.
  - adc_valid[N-1:0] pulses for one cycle, 1 cycle after the last word is presented.
  - Channels >= N hold their data with valid 0.
  - Bad sets in LOCKED (below threshold) suppress valid; data holds.
- k wrap: k wraps 2N-1 -> 0 in VERIFY and LOCKED regardless of the frame value (no re-alignment while locked).
- ch_cnt change: any change of ch_cnt (registered compare) -> SEARCH next cycle, counters cleared, frame_err_cnt kept. ch_cnt > MAX_CH-1 is treated as MAX_CH-1.
- err_clr: clears frame_err_cnt next cycle. If err_clr coincides with an increment, clear wins (result 0).
- Throughput: continuous, no backpressure; consumer must accept every adc_valid.

Test Plan:
- Reset release, ch_cnt=1, DATA_W=6, clean 4-word sets with I0=0xABC, Q0=0x123, I1=0x456, Q1=0x789 (rx_data_r=0x2A, rx_data_f=0x3C for 0xABC) -> locked=1 after the 5th set completes; adc_valid=2'b11 pulses every 4 cycles with slices matching, frame_err_cnt=0.
- ch_cnt=0, FRAME toggling 1/0 -> lock after 5 sets (first set acquires, 4 verify); adc_valid=2'b01 every 2 cycles; channel 1 data stays 0.
- While locked (ch_cnt=1), force rx_frame_f inverted on one word -> frame_err_cnt=1, that set has no valid, next set valid, locked stays 1.
- While locked, corrupt FRAME in 3 consecutive sets (1 word each) -> frame_err_cnt=3, locked falls after the 3rd set; relock after 5 clean sets.
- Locked with frame_err_cnt=7, assert err_clr in the same cycle as a bad word -> count=0 next cycle; at 0xFFFF further errors hold 0xFFFF.
- Change ch_cnt 1->0 while locked -> locked=0 next cycle, no valid until relock; assert rst mid-set -> all outputs 0 immediately, regardless of clock.
